// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use scoreboard, mul/div occupancy,
// redirect flush and data-memory freeze for the 5-stage core.
module hazard_ctrl #(
    parameter int REG_W    = 5,
    parameter int LOAD_LAT = 1,
    parameter int MD_LAT   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic             ex_valid,
    input  logic             ex_load,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_md_start,
    input  logic             ex_jump,
    input  logic             branch_take,
    input  logic             dmem_stall,
    output logic             pc_pause,
    output logic             stall_if_id,
    output logic             stall_id_ex,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic             bubble_ex_mem,
    output logic             stall_mem_wb,
    output logic             md_busy,
    output logic [1:0]       hazard_cause
);

    localparam int NREG = 2 ** REG_W;
    localparam int LW   = $clog2(LOAD_LAT + 1);
    localparam int MW   = (MD_LAT > 1) ? $clog2(MD_LAT) : 1;

    localparam logic [LW-1:0] LD_INIT = LW'(LOAD_LAT - 1);
    localparam logic [MW-1:0] MD_LAST = MW'(MD_LAT - 1);

    logic [LW-1:0] ld_cnt [NREG];
    logic [MW-1:0] md_cnt;

    logic ex_ld_live;
    logic rs1_hit;
    logic rs2_hit;
    logic load_hazard;
    logic md_stall;
    logic redirect;

    assign ex_ld_live = ex_valid && ex_load && (ex_rd != '0);

    assign rs1_hit = id_use_rs1 && (id_rs1 != '0) &&
                     ((ex_ld_live && (id_rs1 == ex_rd)) ||
                      (ld_cnt[id_rs1] != '0));

    assign rs2_hit = id_use_rs2 && (id_rs2 != '0) &&
                     ((ex_ld_live && (id_rs2 == ex_rd)) ||
                      (ld_cnt[id_rs2] != '0));

    assign load_hazard = rs1_hit || rs2_hit;
    assign md_stall    = ex_valid && ex_md_start && (md_cnt != MD_LAST);
    assign redirect    = ex_valid && (branch_take || ex_jump);
    assign md_busy     = md_stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                ld_cnt[i] <= '0;
            end
            md_cnt <= '0;
        end else begin
            if (!dmem_stall) begin
                for (int i = 0; i < NREG; i++) begin
                    if (ex_ld_live && (ex_rd == REG_W'(i))) begin
                        ld_cnt[i] <= LD_INIT;
                    end else if (ld_cnt[i] != '0) begin
                        ld_cnt[i] <= ld_cnt[i] - LW'(1);
                    end
                end
            end
            // A dropped mul/div request abandons progress even when frozen.
            if (!ex_md_start) begin
                md_cnt <= '0;
            end else if (!dmem_stall) begin
                md_cnt <= md_stall ? md_cnt + MW'(1) : '0;
            end
        end
    end

    always_comb begin
        pc_pause      = 1'b0;
        stall_if_id   = 1'b0;
        stall_id_ex   = 1'b0;
        flush_if_id   = 1'b0;
        flush_id_ex   = 1'b0;
        bubble_ex_mem = 1'b0;
        stall_mem_wb  = 1'b0;
        if (dmem_stall) begin
            pc_pause     = 1'b1;
            stall_if_id  = 1'b1;
            stall_id_ex  = 1'b1;
            stall_mem_wb = 1'b1;
        end else if (md_stall) begin
            pc_pause      = 1'b1;
            stall_if_id   = 1'b1;
            stall_id_ex   = 1'b1;
            bubble_ex_mem = 1'b1;
        end else if (redirect) begin
            flush_if_id = 1'b1;
            flush_id_ex = 1'b1;
        end else if (load_hazard) begin
            pc_pause    = 1'b1;
            stall_if_id = 1'b1;
            flush_id_ex = 1'b1;
        end
    end

    always_comb begin
        hazard_cause = 2'd0;
        if (md_stall) begin
            hazard_cause = 2'd3;
        end else if (redirect) begin
            hazard_cause = 2'd2;
        end else if (load_hazard) begin
            hazard_cause = 2'd1;
        end
    end

endmodule
